// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 5x5 keypad encoder.
//   state_t     - encoder FSM states
//   key_class_t - what kind of key a frame resolved to
//   key_t       - class plus code (hex 0..15, operator 0..3, equals 0)
//   map_key()   - row/column position to key_t; unmapped positions give KEY_NONE
package keypad_pkg;

    localparam int NUM_ROWS = 5;
    localparam int NUM_COLS = 5;

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        EMIT,
        HOLD,
        RELEASE
    } state_t;

    typedef enum logic [1:0] {
        KEY_NONE,
        KEY_HEX,
        KEY_OP,
        KEY_EQ
    } key_class_t;

    typedef struct packed {
        key_class_t cls;
        logic [3:0] code;
    } key_t;

    localparam key_t NO_KEY = '{cls: KEY_NONE, code: 4'd0};

    function automatic key_t map_key(input logic [2:0] r, input logic [2:0] c);
        key_t k;
        k = NO_KEY;
        if (r < 3'd4 && c < 3'd4) begin
            k.cls  = KEY_HEX;
            k.code = {r[1:0], c[1:0]};
        end else if (r < 3'd4) begin
            k.cls  = KEY_OP;
            k.code = {2'b00, r[1:0]};
        end else if (c == 3'd0) begin
            k.cls  = KEY_EQ;
        end
        return k;
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// keypad_scan: column scanner and per-frame key resolver.
//   clock     - system clock
//   reset     - synchronous active-low reset
//   rows      - raw active-low row lines (asynchronous)
//   cols      - one-hot active-low column drive
//   frame_vld - high on the last cycle of each frame (last dwell cycle of column 4)
//   frame_key - valid with frame_vld: the single mapped key seen this frame,
//               or NO_KEY when none or more than one mapped key was seen
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] rows,
    output logic [NUM_COLS-1:0] cols,
    output logic                frame_vld,
    output key_t                frame_key
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [2:0]  COL_LAST = 3'(NUM_COLS - 1);

    logic [NUM_ROWS-1:0] rows_meta, rows_sync;
    logic [15:0]         div_cnt;
    logic [2:0]          col;
    logic [1:0]          acc_cnt;   // mapped keys so far this frame, saturates at 2
    key_t                acc_key;
    logic                sample_en;
    logic                last_col;
    logic [2:0]          col_hits;
    key_t                col_key;
    logic [3:0]          hit_sum;
    logic [1:0]          tot_cnt;
    key_t                tot_key;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rows_meta <= '0;
            rows_sync <= '0;
        end else begin
            rows_meta <= rows;
            rows_sync <= rows_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            div_cnt <= '0;
            col     <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            col     <= (col == COL_LAST) ? 3'd0 : col + 3'd1;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    assign cols      = ~(5'b00001 << col);
    // Sampling at the end of the dwell leaves SCAN_DIV-2 cycles for the rows
    // to settle through the synchronizer after the column changes.
    assign sample_en = (div_cnt == DIV_LAST);
    assign last_col  = (col == COL_LAST);

    always_comb begin
        col_hits = '0;
        col_key  = NO_KEY;
        for (int r = 0; r < NUM_ROWS; r++) begin
            // Bottom row is only mapped in column 0 (equals).
            if (!rows_sync[r] && (r < NUM_ROWS - 1 || col == 3'd0)) begin
                col_hits = col_hits + 3'd1;
                col_key  = map_key(3'(r), col);
            end
        end
        hit_sum = {2'b00, acc_cnt} + {1'b0, col_hits};
        tot_cnt = (hit_sum >= 4'd2) ? 2'd2 : hit_sum[1:0];
        tot_key = (acc_cnt == 2'd0) ? col_key : acc_key;
    end

    assign frame_vld = sample_en && last_col;
    assign frame_key = (tot_cnt == 2'd1) ? tot_key : NO_KEY;

    always_ff @(posedge clock) begin
        if (!reset) begin
            acc_cnt <= '0;
            acc_key <= NO_KEY;
        end else if (sample_en) begin
            if (last_col) begin
                acc_cnt <= '0;
                acc_key <= NO_KEY;
            end else begin
                acc_cnt <= tot_cnt;
                acc_key <= tot_key;
            end
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// keypad_encoder: 5x5 keypad scanner with debounce and key-class decoding.
//   clock   - system clock
//   reset   - synchronous active-low reset
//   rows    - raw active-low row lines
//   cols    - one-hot active-low column drive
//   newhex  - one-cycle pulse, hex key accepted (hexcode valid with it)
//   hexcode - last accepted hex key
//   newop   - one-cycle pulse, operator key accepted (opcode valid with it)
//   opcode  - last accepted operator key
//   eq      - one-cycle pulse, equals key accepted
// Optional feature macro KEYPAD_REPEAT_EN: a held hex key re-emits newhex
// every REPEAT_FRAMES frames.
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV      = 1000,
    parameter int DEBOUNCE      = 4,
    parameter int REPEAT_FRAMES = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] rows,
    output logic [NUM_COLS-1:0] cols,
    output logic                newhex,
    output logic [3:0]          hexcode,
    output logic                newop,
    output logic [1:0]          opcode,
    output logic                eq
);

    localparam logic [3:0] DEB = 4'(DEBOUNCE);

    if (SCAN_DIV < 4 || DEBOUNCE < 1 || DEBOUNCE > 15 || REPEAT_FRAMES < 1) begin : g_param_check
        $error("keypad_encoder: parameter out of range");
    end

    logic   frame_vld;
    key_t   frame_key;
    state_t state, state_d;
    logic [3:0] cnt, cnt_d;
    key_t   cand, cand_d;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [15:0] RPT_LAST = 16'(REPEAT_FRAMES);
    logic [15:0] rpt_cnt, rpt_d;
`endif

    keypad_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clock     (clock),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .frame_vld (frame_vld),
        .frame_key (frame_key)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            cand  <= NO_KEY;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt <= '0;
`endif
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            cand  <= cand_d;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt <= rpt_d;
`endif
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        cand_d  = cand;
`ifdef KEYPAD_REPEAT_EN
        rpt_d   = '0;
`endif
        unique case (state)
            IDLE: begin
                if (frame_vld && frame_key.cls != KEY_NONE) begin
                    cand_d  = frame_key;
                    cnt_d   = 4'd1;
                    state_d = (DEB == 4'd1) ? EMIT : PRESS;
                end
            end
            PRESS: begin
                if (frame_vld) begin
                    if (frame_key == cand) begin
                        cnt_d = cnt + 4'd1;
                        if (cnt_d == DEB) state_d = EMIT;
                    end else begin
                        // A different key does not become the new candidate;
                        // it has to start over from IDLE on a later frame.
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            EMIT: begin
                cnt_d   = '0;
                state_d = HOLD;
            end
            HOLD: begin
`ifdef KEYPAD_REPEAT_EN
                rpt_d = rpt_cnt;
`endif
                if (frame_vld) begin
                    if (frame_key.cls == KEY_NONE) begin
                        cnt_d   = 4'd1;
                        state_d = (DEB == 4'd1) ? IDLE : RELEASE;
`ifdef KEYPAD_REPEAT_EN
                        rpt_d   = '0;
                    end else if (frame_key == cand && cand.cls == KEY_HEX) begin
                        if (rpt_cnt + 16'd1 == RPT_LAST) begin
                            rpt_d   = '0;
                            state_d = EMIT;
                        end else begin
                            rpt_d = rpt_cnt + 16'd1;
                        end
                    end else begin
                        rpt_d = '0;
`endif
                    end
                end
            end
            RELEASE: begin
                if (frame_vld) begin
                    if (frame_key.cls == KEY_NONE) begin
                        cnt_d = cnt + 4'd1;
                        if (cnt_d == DEB) state_d = IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pulses and codes are registered on the edge that enters EMIT, so they
    // are visible during the EMIT cycle itself.
    always_ff @(posedge clock) begin
        if (!reset) begin
            newhex  <= 1'b0;
            newop   <= 1'b0;
            eq      <= 1'b0;
            hexcode <= '0;
            opcode  <= '0;
        end else begin
            newhex <= 1'b0;
            newop  <= 1'b0;
            eq     <= 1'b0;
            if (state_d == EMIT) begin
                case (cand_d.cls)
                    KEY_HEX: begin
                        newhex  <= 1'b1;
                        hexcode <= cand_d.code;
                    end
                    KEY_OP: begin
                        newop  <= 1'b1;
                        opcode <= cand_d.code[1:0];
                    end
                    KEY_EQ:  eq <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_encoder.sv
module tb_keypad_encoder;

    localparam int SD    = 4;
    localparam int DEB   = 3;
    localparam int RPT   = 8;
    localparam int FRAME = 5 * SD;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] rows;
    logic [4:0] cols;
    logic       newhex, newop, eq;
    logic [3:0] hexcode;
    logic [1:0] opcode;

    logic [4:0][4:0] pressed = '0;   // pressed[row][col]

    int checks = 0;
    int failures = 0;
    int n_hex = 0, n_op = 0, n_eq = 0;

    // reference model state (frame-level)
    bit pend_hex, pend_op, pend_eq;
    int exp_hex, exp_op;
    int m_run, m_runkey, m_none, m_rep, m_heldkey;
    bit m_held;

    keypad_encoder #(.SCAN_DIV(SD), .DEBOUNCE(DEB), .REPEAT_FRAMES(RPT)) dut (
        .clock   (clock),
        .reset   (reset),
        .rows    (rows),
        .cols    (cols),
        .newhex  (newhex),
        .hexcode (hexcode),
        .newop   (newop),
        .opcode  (opcode),
        .eq      (eq)
    );

    always #5 clock = ~clock;

    // Passive keypad: a row is pulled low when a pressed key connects it to the driven column.
    always_comb begin
        rows = '1;
        for (int r = 0; r < 5; r++)
            if (|(pressed[r] & ~cols)) rows[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Key id of the frame: 0..15 hex, 16..19 operator, 20 equals, -1 none or multiple.
    function automatic int frame_id();
        int n = 0;
        int id = -1;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                if (pressed[r][c]) begin
                    if (r < 4 && c < 4)  begin n++; id = 4 * r + c; end
                    else if (r < 4)      begin n++; id = 16 + r; end
                    else if (c == 0)     begin n++; id = 20; end
                end
        return (n == 1) ? id : -1;
    endfunction

    task automatic model_emit(input int id);
        if (id < 16)      begin pend_hex = 1; exp_hex = id; end
        else if (id < 20) begin pend_op = 1;  exp_op = id - 16; end
        else              pend_eq = 1;
    endtask

    task automatic model_reset();
        pend_hex = 0; pend_op = 0; pend_eq = 0;
        exp_hex = 0; exp_op = 0;
        m_run = 0; m_runkey = -1; m_none = 0; m_rep = 0; m_heldkey = -1; m_held = 0;
    endtask

    task automatic model_frame(input int id);
        if (!m_held) begin
            if (id < 0)                 m_run = 0;
            else if (m_run == 0)        begin m_run = 1; m_runkey = id; end
            else if (id == m_runkey)    m_run++;
            else                        m_run = 0;
            if (m_run == DEB) begin
                model_emit(id);
                m_held = 1; m_heldkey = id; m_none = 0; m_rep = 0; m_run = 0;
            end
        end else if (id < 0) begin
            m_none++;
            m_rep = 0;
            if (m_none == DEB) begin m_held = 0; m_run = 0; end
        end else begin
`ifdef KEYPAD_REPEAT_EN
            // only frames seen while the key was continuously held count
            if (m_none == 0 && id == m_heldkey && id < 16) begin
                m_rep++;
                if (m_rep == RPT) begin model_emit(id); m_rep = 0; end
            end else begin
                m_rep = 0;
            end
`endif
            m_none = 0;
        end
    endtask

    // Runs ncyc cycles of a frame; entry and exit are #1 after a rising edge.
    task automatic run_frame(input int ncyc);
        logic [4:0] col_exp;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            col_exp = ~(5'b00001 << (cyc / SD));
            chk("cols", 8'(cols), 8'(col_exp));
            chk("newhex", 8'(newhex), 8'((cyc == 0) ? pend_hex : 1'b0));
            chk("newop", 8'(newop), 8'((cyc == 0) ? pend_op : 1'b0));
            chk("eq", 8'(eq), 8'((cyc == 0) ? pend_eq : 1'b0));
            chk("hexcode", 8'(hexcode), 8'(exp_hex));
            chk("opcode", 8'(opcode), 8'(exp_op));
            if (newhex === 1'b1) n_hex++;
            if (newop === 1'b1)  n_op++;
            if (eq === 1'b1)     n_eq++;
            if (cyc == 0) begin pend_hex = 0; pend_op = 0; pend_eq = 0; end
            @(posedge clock); #1;
        end
        if (ncyc == FRAME) model_frame(frame_id());
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) run_frame(FRAME);
    endtask

    task automatic press1(input int r, input int c);
        pressed = '0;
        pressed[r][c] = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        pressed = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("rst_cols", 8'(cols), 8'h1e);
            chk("rst_pulses", 8'({newhex, newop, eq}), 8'h00);
            chk("rst_hexcode", 8'(hexcode), 8'h00);
            chk("rst_opcode", 8'(opcode), 8'h00);
        end
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset();

        // hex 7 held 10 frames: exactly one pulse
        n_hex = 0;
        press1(1, 3); frames(10);
        pressed = '0; frames(4);
        chk("r033_count", 8'(n_hex), 8'd1);
        chk("r033_code", 8'(hexcode), 8'd7);

        // operator 2: short press ignored, full press accepted
        n_op = 0;
        press1(2, 4); frames(2);
        pressed = '0; frames(1);
        chk("r034_nopulse", 8'(n_op), 8'd0);
        press1(2, 4); frames(3);
        pressed = '0; frames(4);
        chk("r034_count", 8'(n_op), 8'd1);
        chk("r034_code", 8'(opcode), 8'd2);

        // two keys together ignored until one is released
        n_hex = 0;
        pressed = '0; pressed[0][0] = 1'b1; pressed[3][3] = 1'b1; frames(6);
        chk("r035_multi", 8'(n_hex), 8'd0);
        press1(0, 0); frames(3);
        pressed = '0; frames(4);
        chk("r035_count", 8'(n_hex), 8'd1);
        chk("r035_code", 8'(hexcode), 8'd0);

        // equals: short release does not re-arm, full release does
        n_eq = 0;
        press1(4, 0); frames(3);
        pressed = '0; frames(1);
        press1(4, 0); frames(2);
        chk("r036_one", 8'(n_eq), 8'd1);
        pressed = '0; frames(3);
        press1(4, 0); frames(3);
        pressed = '0; frames(4);
        chk("r036_two", 8'(n_eq), 8'd2);

        // unmapped keys on the bottom row
        n_hex = 0; n_op = 0; n_eq = 0;
        press1(4, 2); frames(4);
        pressed = '0; frames(1);
        chk("unmapped", 8'(n_hex + n_op + n_eq), 8'd0);

        // reset in the middle of the 2nd debounce frame of key 5
        n_hex = 0;
        press1(1, 1); frames(1); run_frame(7);
        do_reset();
        frames(5);
        chk("r037_nopulse", 8'(n_hex), 8'd0);

        // randomized key sequences against the model
        for (int s = 0; s < 30; s++) begin
            int kind, r, c;
            kind = int'($urandom_range(0, 3));
            pressed = '0;
            if (kind == 1) begin
                r = int'($urandom_range(0, 4));
                c = (r == 4) ? 0 : int'($urandom_range(0, 4));
                pressed[r][c] = 1'b1;
            end else if (kind >= 2) begin
                pressed[$urandom_range(0, 4)][$urandom_range(0, 4)] = 1'b1;
                if (kind == 3) pressed[$urandom_range(0, 4)][$urandom_range(0, 4)] = 1'b1;
            end
            frames(int'($urandom_range(1, 5)));
        end
        pressed = '0; frames(4);

        // long hold of key A
        do_reset();
        n_hex = 0;
        press1(2, 2); frames(30);
        pressed = '0; frames(4);
`ifdef KEYPAD_REPEAT_EN
        chk("r038_count", 8'(n_hex), 8'd4);
`else
        chk("hold_count", 8'(n_hex), 8'd1);
`endif
        chk("hold_code", 8'(hexcode), 8'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_encoder.md
KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 1000: clock cycles each column is driven, range 4..65535.
REQ-002 SHALL provide parameter DEBOUNCE, default 4: consecutive identical frames required to accept a press or a release, range 1..15.
REQ-003 SHALL provide parameter REPEAT_FRAMES, default 64: frames between auto-repeat pulses; used only when KEYPAD_REPEAT_EN is defined.
REQ-004 clock  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-006 rows  input  5  keypad row lines, active-low, asynchronous to clock.
REQ-007 cols  output  5  column drive, one-hot active-low.
REQ-008 newhex  output  1  one-cycle pulse when a hex key is accepted.
REQ-009 hexcode  output  4  value of the last accepted hex key.
REQ-010 newop  output  1  one-cycle pulse when an operator key is accepted.
REQ-011 opcode  output  2  value of the last accepted operator key.
REQ-012 eq  output  1  one-cycle pulse when the equals key is accepted.

Function
REQ-013 SHALL pass rows through a 2-flop synchronizer before any use.
REQ-014 SHALL drive one column for SCAN_DIV cycles, advancing 0,1,2,3,4 and wrapping 4->0; frame = 5*SCAN_DIV cycles.
REQ-015 SHALL sample the synchronized rows only on the last cycle of each column dwell.
REQ-016 Key map: row r<4, col c<4 -> hex 4*r+c; row r<4, col 4 -> operator r; row 4, col 0 -> equals; row 4, cols 1-4 -> unmapped, ignored.
REQ-017 At frame end, the frame result SHALL be NONE (zero mapped keys), KEY (exactly one, with its code) or MULTI (two or more); MULTI SHALL be handled as NONE.
REQ-018 FSM states SHALL be IDLE, PRESS, EMIT, HOLD, RELEASE.
REQ-019 IDLE: on KEY -> PRESS, candidate = code, count = 1.
REQ-020 PRESS: same KEY -> count+1, and on count = DEBOUNCE -> EMIT; NONE or a different KEY -> IDLE.
REQ-021 EMIT: assert exactly one of newhex/newop/eq for one cycle, update hexcode or opcode in the same cycle, then -> HOLD.
REQ-022 The pulse SHALL occur on the first cycle after the frame end that completes the DEBOUNCE-th matching frame.
REQ-023 HOLD: on NONE -> RELEASE, count = 1; any KEY -> stay in HOLD.
REQ-024 RELEASE: NONE -> count+1, and on count = DEBOUNCE -> IDLE; any KEY -> HOLD.
REQ-025 hexcode and opcode SHALL hold their value between pulses; at most one pulse SHALL be high in any cycle.
REQ-026 A held key SHALL produce exactly one pulse unless KEYPAD_REPEAT_EN is defined.

Reset
REQ-027 While reset is low at a clock edge: FSM -> IDLE, counters and synchronizer = 0, cols = 5'b11110, newhex = newop = eq = 0, hexcode = 0, opcode = 0.
REQ-028 Reset asserted mid-debounce or mid-hold SHALL discard the candidate; no pulse is emitted for it.

Configuration
REQ-029 With macro KEYPAD_REPEAT_EN defined, in HOLD a hex key still pressed SHALL re-emit newhex (same hexcode) every REPEAT_FRAMES frames; operator and equals keys SHALL never repeat.
REQ-030 Without KEYPAD_REPEAT_EN, no repeat logic or counter SHALL be synthesized.

Structure
REQ-031 Package keypad_pkg SHALL hold the FSM state enum, the key-class enum (HEX/OP/EQ/NONE), and NUM_ROWS = NUM_COLS = 5.
REQ-032 Sub-module keypad_scan SHALL contain the column timer, synchronizer, row sampling and frame result; keypad_encoder SHALL contain the FSM and outputs.

Verification (SCAN_DIV=4, DEBOUNCE=3, frame = 20 cycles)
REQ-033 Hold row1/col3 for 10 frames -> exactly one newhex pulse, hexcode=7, 1 cycle after the 3rd frame end.
REQ-034 Hold row2/col4 for 2 frames, then release -> no pulse; then hold 3 frames -> newop pulse, opcode=2.
REQ-035 Press row0/col0 and row3/col3 together for 6 frames -> no pulse; then release row3 -> newhex, hexcode=0, after 3 further frames.
REQ-036 Press row4/col0 -> eq pulse; release 1 frame, re-press -> no second pulse; release 3 frames, re-press 3 frames -> second eq pulse.
REQ-037 Assert reset during the 2nd debounce frame of key 5 -> no pulse, cols=5'b11110, all outputs 0.
REQ-038 KEYPAD_REPEAT_EN defined, REPEAT_FRAMES=8, hold key A for 30 frames -> newhex pulses at frame ends 3, 11, 19, 27, all with hexcode=A.
